// File: rtl/pcs_loopback_mon.sv
// TX-side PCS stream monitor: checks framing legality and frame length, and keeps
// saturating statistics plus a sticky fault flag for on-board readout.
module pcs_loopback_mon #(
   parameter int DATA_W      = 64,
   parameter int LANE0_CNT_N = 2,
   parameter int MIN_LEN     = 64,
   parameter int MAX_LEN     = 1518,
   parameter int CNT_W       = 32,
   parameter int LEN_W       = 16,
   parameter int KEEP_W      = DATA_W / 8
) (
   input  logic                   tx_clk,
   input  logic                   tx_nreset,
   input  logic                   clr_i,
   input  logic                   pcs_valid_i,
   input  logic                   pcs_ctrl_i,
   input  logic                   pcs_idle_i,
   input  logic                   pcs_term_i,
   input  logic                   pcs_err_i,
   input  logic [LANE0_CNT_N-1:0] pcs_start_i,
   input  logic [DATA_W-1:0]      pcs_data_i,
   input  logic [KEEP_W-1:0]      pcs_keep_i,
   output logic                   in_frame_o,
   output logic [CNT_W-1:0]       frame_cnt_o,
   output logic [CNT_W-1:0]       proto_err_cnt_o,
   output logic [CNT_W-1:0]       len_err_cnt_o,
   output logic [CNT_W-1:0]       pcs_err_cnt_o,
   output logic [LEN_W-1:0]       last_len_o,
   output logic                   fault_o
);
   localparam int SAT = MAX_LEN + 1;

   typedef enum logic {IDLE, IN_FRAME} state_t;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len, len_nxt;

   // Payload bytes never matter here; only keep carries length information.
   logic data_unused;
   assign data_unused = ^pcs_data_i;

   logic             start_nz, ctrl_ok, keep_full, keep_therm, in_range;
   logic [KEEP_W-1:0] keep_inc;
   logic [LEN_W-1:0] pop, len_data, len_final;
   logic [LEN_W:0]   sum_data, sum_term;
   logic [1:0]       n_ctrl;

   always_comb begin
      start_nz   = |pcs_start_i;
      n_ctrl     = 2'(pcs_idle_i) + 2'(start_nz) + 2'(pcs_term_i);
      ctrl_ok    = (n_ctrl == 2'd1) && (!start_nz || $onehot(pcs_start_i));
      keep_full  = &pcs_keep_i;
      keep_inc   = pcs_keep_i + KEEP_W'(1);
      keep_therm = ((pcs_keep_i & keep_inc) == '0);
      pop        = LEN_W'($countones(pcs_keep_i));
      // Sums are one bit wider so the saturation compare cannot wrap.
      sum_data   = {1'b0, len} + (LEN_W+1)'(KEEP_W);
      sum_term   = {1'b0, len} + {1'b0, pop};
      len_data   = (sum_data > (LEN_W+1)'(SAT)) ? LEN_W'(SAT) : sum_data[LEN_W-1:0];
      len_final  = (sum_term > (LEN_W+1)'(SAT)) ? LEN_W'(SAT) : sum_term[LEN_W-1:0];
      in_range   = (len_final >= LEN_W'(MIN_LEN)) && (len_final <= LEN_W'(MAX_LEN));
   end

   logic ev_frame, ev_proto, ev_len, ev_pcs, ev_last;

   always_ff @(posedge tx_clk) begin
      if (!tx_nreset) begin
         state <= IDLE;
         len   <= '0;
      end else begin
         state <= state_nxt;
         len   <= len_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      len_nxt   = len;
      ev_frame  = 1'b0;
      ev_proto  = 1'b0;
      ev_len    = 1'b0;
      ev_pcs    = 1'b0;
      ev_last   = 1'b0;
      if (pcs_valid_i) begin
         if (pcs_err_i) begin
            ev_pcs    = 1'b1;
            state_nxt = IDLE;
         end else if (!pcs_ctrl_i) begin
            if (state == IDLE) ev_proto = 1'b1;
            else if (keep_full) len_nxt = len_data;
            else begin
               ev_proto  = 1'b1;
               state_nxt = IDLE;
            end
         end else if (!ctrl_ok) begin
            ev_proto  = 1'b1;
            state_nxt = IDLE;
         end else if (pcs_idle_i) begin
            if (state == IN_FRAME) begin
               ev_proto  = 1'b1;
               state_nxt = IDLE;
            end
         end else if (start_nz) begin
            // A start inside a frame drops the old frame and opens a new one.
            if (state == IN_FRAME) ev_proto = 1'b1;
            state_nxt = IN_FRAME;
            len_nxt   = '0;
         end else if (state == IDLE) begin
            ev_proto = 1'b1;
         end else begin
            state_nxt = IDLE;
            if (keep_therm) begin
               ev_last  = 1'b1;
               ev_frame = in_range;
               ev_len   = !in_range;
            end else begin
               ev_proto = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_frame_o = (state == IN_FRAME);
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge tx_clk) begin
      if (!tx_nreset || clr_i) begin
         frame_cnt_o     <= '0;
         proto_err_cnt_o <= '0;
         len_err_cnt_o   <= '0;
         pcs_err_cnt_o   <= '0;
         last_len_o      <= '0;
         fault_o         <= 1'b0;
      end else begin
         if (ev_frame) frame_cnt_o     <= sat_inc(frame_cnt_o);
         if (ev_proto) proto_err_cnt_o <= sat_inc(proto_err_cnt_o);
         if (ev_len)   len_err_cnt_o   <= sat_inc(len_err_cnt_o);
         if (ev_pcs)   pcs_err_cnt_o   <= sat_inc(pcs_err_cnt_o);
         if (ev_last)  last_len_o      <= len_final;
         if (ev_proto || ev_len || ev_pcs) fault_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pcs_loopback_mon.sv
// Directed bench: driver pushes hand-computed expectations, monitor compares them
// one cycle after the word is sampled.
module tb_pcs_loopback_mon;
   logic        tx_clk = 1'b0;
   logic        tx_nreset, clr_i;
   logic        pcs_valid_i, pcs_ctrl_i, pcs_idle_i, pcs_term_i, pcs_err_i;
   logic [1:0]  pcs_start_i;
   logic [63:0] pcs_data_i;
   logic [7:0]  pcs_keep_i;
   logic        in_frame_o, fault_o;
   logic [31:0] frame_cnt_o, proto_err_cnt_o, len_err_cnt_o, pcs_err_cnt_o;
   logic [15:0] last_len_o;

   pcs_loopback_mon dut (
      .tx_clk(tx_clk), .tx_nreset(tx_nreset), .clr_i(clr_i),
      .pcs_valid_i(pcs_valid_i), .pcs_ctrl_i(pcs_ctrl_i), .pcs_idle_i(pcs_idle_i),
      .pcs_term_i(pcs_term_i), .pcs_err_i(pcs_err_i), .pcs_start_i(pcs_start_i),
      .pcs_data_i(pcs_data_i), .pcs_keep_i(pcs_keep_i), .in_frame_o(in_frame_o),
      .frame_cnt_o(frame_cnt_o), .proto_err_cnt_o(proto_err_cnt_o),
      .len_err_cnt_o(len_err_cnt_o), .pcs_err_cnt_o(pcs_err_cnt_o),
      .last_len_o(last_len_o), .fault_o(fault_o));

   always #5 tx_clk = ~tx_clk;

   int cyc = 0;
   always @(posedge tx_clk) cyc <= cyc + 1;

   typedef struct {
      string name;
      int    due;
      int    inf, fr, pe, le, pc, ll, flt;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input string fld, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s.%s: got %0d, expected %0d", name, fld, act, req);
   endtask

   always @(negedge tx_clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         if (e.due != cyc) chk(e.name, "late", cyc, e.due);
         chk(e.name, "in_frame",  int'(in_frame_o),      e.inf);
         chk(e.name, "frame_cnt", int'(frame_cnt_o),     e.fr);
         chk(e.name, "proto_cnt", int'(proto_err_cnt_o), e.pe);
         chk(e.name, "len_cnt",   int'(len_err_cnt_o),   e.le);
         chk(e.name, "pcs_cnt",   int'(pcs_err_cnt_o),   e.pc);
         chk(e.name, "last_len",  int'(last_len_o),      e.ll);
         chk(e.name, "fault",     int'(fault_o),         e.flt);
      end
   end

   // Expectation for the word just driven, visible one cycle later.
   task automatic expect_now(input string name, input int inf, fr, pe, le, pc, ll, flt);
      exp_t e;
      e.name = name; e.due = cyc + 1;
      e.inf = inf; e.fr = fr; e.pe = pe; e.le = le; e.pc = pc; e.ll = ll; e.flt = flt;
      sb.push_back(e);
   endtask

   task automatic put(input logic v, c, i, t, e, input logic [1:0] s,
                      input logic [7:0] k, input logic clr);
      @(negedge tx_clk);
      tx_nreset   = 1'b1;
      pcs_valid_i = v; pcs_ctrl_i = c; pcs_idle_i = i; pcs_term_i = t;
      pcs_err_i   = e; pcs_start_i = s; pcs_keep_i = k; clr_i = clr;
      pcs_data_i  = {$urandom, $urandom};
   endtask

   task automatic w_idle();                  put(1, 1, 1, 0, 0, 2'b00, 8'h00, 0); endtask
   task automatic w_start(input logic [1:0] s); put(1, 1, 0, 0, 0, s, 8'h00, 0); endtask
   task automatic w_data(input int n);
      for (int j = 0; j < n; j++) put(1, 0, 0, 0, 0, 2'b00, 8'hFF, 0);
   endtask
   task automatic w_term(input logic [7:0] k); put(1, 1, 0, 1, 0, 2'b00, k, 0); endtask
   // Slip cycle carrying garbage that must be ignored.
   task automatic w_slip();                  put(0, 1, 1, 1, 1, 2'b11, 8'h5A, 0); endtask

   initial begin
      tx_nreset = 1'b0; clr_i = 1'b0;
      pcs_valid_i = 1'b1; pcs_ctrl_i = 1'b1; pcs_idle_i = 1'b0; pcs_term_i = 1'b1;
      pcs_err_i = 1'b1; pcs_start_i = 2'b01; pcs_keep_i = 8'hFF; pcs_data_i = '0;
      @(negedge tx_clk);
      @(negedge tx_clk);
      expect_now("reset", 0, 0, 0, 0, 0, 0, 0);

      // 1: short frame, 56+4 = 60 bytes
      repeat (4) w_idle();
      expect_now("t1_idle", 0, 0, 0, 0, 0, 0, 0);
      w_start(2'b01);
      expect_now("t1_start", 1, 0, 0, 0, 0, 0, 0);
      w_data(7);
      w_term(8'h0F);
      expect_now("t1_term", 0, 0, 0, 1, 0, 60, 1);

      // 2: 64+3 = 67 bytes with slips on cycles 3 and 6
      w_start(2'b01);
      w_data(1);
      w_slip();
      expect_now("t2_slip", 1, 0, 0, 1, 0, 60, 1);
      w_data(2);
      w_slip();
      w_data(5);
      expect_now("t2_data", 1, 0, 0, 1, 0, 60, 1);
      w_term(8'h07);
      expect_now("t2_term", 0, 1, 0, 1, 0, 67, 1);

      // 3: restart inside frame, then exactly MIN_LEN
      w_start(2'b01);
      w_data(2);
      w_start(2'b10);
      expect_now("t3_restart", 1, 1, 1, 1, 0, 67, 1);
      w_data(8);
      w_term(8'h00);
      expect_now("t3_term", 0, 2, 1, 1, 0, 64, 1);

      // 4: error word aborts, trailing DATA and TERM hit IDLE
      w_start(2'b01);
      w_data(3);
      put(1, 0, 0, 0, 1, 2'b00, 8'hFF, 0);
      expect_now("t4_err", 0, 2, 1, 1, 1, 64, 1);
      w_data(1);
      expect_now("t4_data", 0, 2, 2, 1, 1, 64, 1);
      w_term(8'hFF);
      expect_now("t4_term", 0, 2, 3, 1, 1, 64, 1);

      // 5: over-long frame saturates at MAX_LEN+1, then non-thermometer keep
      w_start(2'b01);
      w_data(190);
      expect_now("t5_long", 1, 2, 3, 1, 1, 64, 1);
      w_term(8'hFF);
      expect_now("t5_term", 0, 2, 3, 2, 1, 1519, 1);
      w_start(2'b01);
      w_term(8'h05);
      expect_now("t5_badkeep", 0, 2, 4, 2, 1, 1519, 1);

      // exactly MAX_LEN: 189*8 + 6
      w_start(2'b10);
      w_data(189);
      w_term(8'h3F);
      expect_now("max_len", 0, 3, 4, 2, 1, 1518, 1);

      // illegal control words: idle+term inside frame, multi-hot start in IDLE
      w_start(2'b10);
      w_data(1);
      put(1, 1, 1, 1, 0, 2'b00, 8'h00, 0);
      expect_now("ill_abort", 0, 3, 5, 2, 1, 1518, 1);
      w_start(2'b11);
      expect_now("ill_start", 0, 3, 6, 2, 1, 1518, 1);

      // 6: clr coinciding with a good TERM drops the event, FSM still closes
      w_start(2'b01);
      w_data(8);
      expect_now("t6_pre", 1, 3, 6, 2, 1, 1518, 1);
      put(1, 1, 0, 1, 0, 2'b00, 8'hFF, 1);
      expect_now("t6_clr", 0, 0, 0, 0, 0, 0, 0);
      w_start(2'b01);
      w_data(8);
      w_term(8'h01);
      expect_now("t6_after", 0, 1, 0, 0, 0, 65, 0);

      w_idle();
      for (int j = 0; j < 50 && sb.size() > 0; j++) @(negedge tx_clk);
      if (sb.size() > 0) chk("drain", "pending", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
